// File: rtl/bus_master_interface.sv
// rtl/bus_master_interface.sv - serial system bus initiator; optional response timeout under MASTER_TIMEOUT_EN
module bus_master_interface
`ifdef MASTER_TIMEOUT_EN
#(
    parameter int TIMEOUT = 32,
    parameter int TO_W    = 6
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_slave,
    input  logic [11:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic [7:0]  rd_data,
    output logic        done,
    output logic        error,
    output logic        bus_request,
    input  logic        bus_grant,
    output logic        master_en,
    output logic        addr,
    output logic        w_data,
    input  logic        r_data,
    input  logic [1:0]  response
);

    localparam logic [1:0] RESP_NAK  = 2'b00;
    localparam logic [1:0] RESP_BUSY = 2'b01;
    localparam logic [1:0] RESP_OK   = 2'b10;
    localparam logic [1:0] RESP_DONE = 2'b11;

    typedef enum logic [3:0] {
        IDLE, REQUEST, START, SEND_ADDR, WAIT_RESP, WGAP, SEND_WDATA,
        RGAP, RECV_RDATA, WAIT_DONE, FINISH, SPLIT, ABORT
    } state_t;

    state_t      state, next_state;
    logic [14:0] hdr;
    logic [7:0]  wdata_q;
    logic [7:0]  rx_shift;
    logic [3:0]  bit_cnt;
    logic        to_expired;

`ifdef MASTER_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    // to_cnt includes the current wait cycle, so the abort lands TIMEOUT cycles after entry
    assign to_expired = (response == RESP_NAK) && (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
        end else if ((next_state == WAIT_RESP || next_state == WAIT_DONE) && next_state != state) begin
            to_cnt <= TO_W'(1);
        end else if ((state == WAIT_RESP || state == WAIT_DONE) && response == RESP_NAK && to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hdr      <= '0;
            wdata_q  <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            rd_data  <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        hdr     <= {req_slave, req_write, req_addr};
                        wdata_q <= req_wdata;
                    end
                end
                START:                              bit_cnt <= 4'd14;
                WGAP, RGAP:                         bit_cnt <= 4'd7;
                SEND_ADDR, SEND_WDATA, RECV_RDATA:  bit_cnt <= bit_cnt - 1'b1;
                default: ;
            endcase
            if (state == RECV_RDATA)
                rx_shift <= {rx_shift[6:0], r_data};
            if (next_state == FINISH && !hdr[12])
                rd_data <= rx_shift;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (req_valid) next_state = REQUEST;
            REQUEST:    if (bus_grant) next_state = START;
            START:      next_state = SEND_ADDR;
            SEND_ADDR:  if (bit_cnt == 4'd0) next_state = WAIT_RESP;
            WAIT_RESP: begin
                case (response)
                    RESP_NAK:  if (to_expired) next_state = ABORT;
                    RESP_BUSY: next_state = SPLIT;
                    RESP_OK:   next_state = hdr[12] ? WGAP : ABORT;
                    RESP_DONE: next_state = hdr[12] ? ABORT : RGAP;
                    default: ;
                endcase
            end
            WGAP:       next_state = SEND_WDATA;
            SEND_WDATA: if (bit_cnt == 4'd0) next_state = WAIT_DONE;
            RGAP:       next_state = RECV_RDATA;
            RECV_RDATA: if (bit_cnt == 4'd0) next_state = WAIT_DONE;
            WAIT_DONE: begin
                if (response == RESP_DONE)
                    next_state = FINISH;
                else if (to_expired)
                    next_state = ABORT;
            end
            SPLIT:      if (bus_grant) next_state = WAIT_RESP;
            FINISH:     next_state = IDLE;
            ABORT:      next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = 1'b0;
        bus_request = 1'b0;
        master_en   = 1'b0;
        addr        = 1'b0;
        w_data      = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        case (state)
            IDLE:    req_ready = 1'b1;
            REQUEST: bus_request = 1'b1;
            START: begin
                bus_request = 1'b1;
                master_en   = 1'b1;
                addr        = 1'b1;
            end
            SEND_ADDR: begin
                bus_request = 1'b1;
                master_en   = 1'b1;
                addr        = hdr[bit_cnt];
            end
            SEND_WDATA: begin
                bus_request = 1'b1;
                master_en   = 1'b1;
                w_data      = wdata_q[bit_cnt[2:0]];
            end
            WAIT_RESP, WGAP, RGAP, RECV_RDATA, WAIT_DONE: begin
                bus_request = 1'b1;
                master_en   = 1'b1;
            end
            FINISH:  done = 1'b1;
            ABORT: begin
                done  = 1'b1;
                error = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_master_interface.sv
// tb/tb_bus_master_interface.sv - self-checking bench for bus_master_interface (bench acts as device, arbiter and slave)
module tb_bus_master_interface;

    localparam logic [1:0] NAK = 2'b00, BUSY = 2'b01, OK = 2'b10, DN = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_slave = '0;
    logic [11:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic [7:0]  rd_data;
    logic        done, error, bus_request, master_en, addr, w_data;
    logic        bus_grant = 1'b0;
    logic        r_data = 1'b0;
    logic [1:0]  response = NAK;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] exp_rd = 8'h00;

    logic [14:0] obs_hdr;
    logic [7:0]  obs_wbits, obs_rd;
    logic obs_gap, obs_done, obs_error, obs_hang, obs_early_done, obs_ready_busy;
    logic obs_split_rel, obs_resend, obs_regain, obs_br_fin, obs_br_after, obs_ready_after;

    bus_master_interface dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_slave(req_slave), .req_addr(req_addr), .req_wdata(req_wdata),
        .rd_data(rd_data), .done(done), .error(error), .bus_request(bus_request),
        .bus_grant(bus_grant), .master_en(master_en), .addr(addr), .w_data(w_data),
        .r_data(r_data), .response(response)
    );

    always #5 clk = ~clk;

    // One whole transaction seen from the device, arbiter and slave side; starts and ends on an IDLE negedge.
    task automatic do_transfer(input logic wr, input logic [1:0] sl, input logic [11:0] ad,
                               input logic [7:0] wd, input logic [7:0] rd, input int naks,
                               input int busy_delay, input bit bad, input bit hold, input int rst_bit);
        int n;
        int gd;
        obs_hdr = '0; obs_wbits = '0; obs_rd = '0; obs_gap = 1'b0; obs_done = 1'b0; obs_error = 1'b0;
        obs_hang = 1'b0; obs_early_done = 1'b0; obs_ready_busy = 1'b0; obs_split_rel = 1'b0;
        obs_resend = 1'b0; obs_regain = 1'b0; obs_br_fin = 1'b1; obs_br_after = 1'b1; obs_ready_after = 1'b0;
        req_write = wr; req_slave = sl; req_addr = ad; req_wdata = wd; req_valid = 1'b1;
        response = NAK; r_data = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin obs_hang = 1'b1; req_valid = 1'b0; return; end
        @(negedge clk);
        if (hold) begin
            req_addr = 12'($urandom); req_wdata = 8'($urandom);
            req_slave = 2'($urandom); req_write = 1'($urandom);
        end else begin
            req_valid = 1'b0;
        end
        if (req_ready !== 1'b0) obs_ready_busy = 1'b1;
        gd = $urandom_range(0, 3);
        for (int k = 0; k < gd; k++) @(negedge clk);
        bus_grant = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(addr === 1'b1 && master_en === 1'b1) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin obs_hang = 1'b1; return; end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            obs_hdr = {obs_hdr[13:0], addr};
        end
        for (int i = 0; i < naks; i++) begin
            @(negedge clk);
            response = NAK;
            if (done !== 1'b0) obs_early_done = 1'b1;
        end
        @(negedge clk);
        if (busy_delay > 0) begin
            response = BUSY;
            obs_split_rel = 1'b1;
            for (int i = 0; i < busy_delay; i++) begin
                @(negedge clk);
                if (i == 0) begin bus_grant = 1'b0; response = NAK; end
                if (bus_request !== 1'b0 || master_en !== 1'b0) obs_split_rel = 1'b0;
                if (addr !== 1'b0) obs_resend = 1'b1;
                if (i == busy_delay - 1) bus_grant = 1'b1;
            end
            @(negedge clk);
            obs_regain = (bus_request === 1'b1 && master_en === 1'b1);
            if (addr !== 1'b0) obs_resend = 1'b1;
        end
        response = (wr ^ bad) ? OK : DN;
        if (bad) begin
            @(negedge clk);
            obs_done = done; obs_error = error; obs_rd = rd_data;
            obs_br_fin = bus_request | master_en;
            response = NAK; bus_grant = 1'b0;
            @(negedge clk);
            obs_br_after = bus_request; obs_ready_after = req_ready;
            return;
        end
        if (wr) begin
            @(negedge clk);
            obs_gap = w_data; response = NAK;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                obs_wbits = {obs_wbits[6:0], w_data};
                if (i == rst_bit) begin reset = 1'b1; bus_grant = 1'b0; req_valid = 1'b0; return; end
            end
        end else begin
            @(negedge clk);
            response = NAK; r_data = ~rd[7];
            for (int i = 7; i >= 0; i--) begin @(negedge clk); r_data = rd[i]; end
        end
        @(negedge clk); r_data = 1'($urandom); response = NAK;
        @(negedge clk); response = DN;
        @(negedge clk);
        obs_done = done; obs_error = error; obs_rd = rd_data;
        obs_br_fin = bus_request | master_en;
        if (req_ready !== 1'b0) obs_ready_busy = 1'b1;
        response = NAK; bus_grant = 1'b0;
        @(negedge clk);
        obs_br_after = bus_request; obs_ready_after = req_ready;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if ({req_ready, bus_request, master_en, addr, w_data, done, error} !== 7'b1000000) begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", {req_ready, bus_request, master_en, addr, w_data, done, error}, 7'b1000000); end
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write;
        do_transfer(1'b1, 2'd2, 12'h0A5, 8'h3C, 8'h00, 2, 0, 0, 0, -1);
        n_checks++; if (obs_hdr !== 15'b101_0000_1010_0101) begin n_fail++; $display("FAIL write_header: got %h expected %h", obs_hdr, 15'b101_0000_1010_0101); end
        n_checks++; if (obs_gap !== 1'b0) begin n_fail++; $display("FAIL write_gap: got %b expected 0", obs_gap); end
        n_checks++; if (obs_wbits !== 8'h3C) begin n_fail++; $display("FAIL write_data: got %h expected 3c", obs_wbits); end
        n_checks++; if ({obs_done, obs_error} !== 2'b10) begin n_fail++; $display("FAIL write_status: got %b expected 10", {obs_done, obs_error}); end
        n_checks++; if (obs_rd !== exp_rd) begin n_fail++; $display("FAIL write_rd_kept: got %h expected %h", obs_rd, exp_rd); end
    endtask

    task automatic test_read;
        do_transfer(1'b0, 2'd1, 12'hFFF, 8'h00, 8'hA7, 0, 0, 0, 0, -1);
        exp_rd = 8'hA7;
        n_checks++; if (obs_hdr !== 15'h2FFF) begin n_fail++; $display("FAIL read_header: got %h expected 2fff", obs_hdr); end
        n_checks++; if (obs_rd !== exp_rd) begin n_fail++; $display("FAIL read_data: got %h expected %h", obs_rd, exp_rd); end
        n_checks++; if ({obs_done, obs_error} !== 2'b10) begin n_fail++; $display("FAIL read_status: got %b expected 10", {obs_done, obs_error}); end
        n_checks++; if ({obs_br_after, obs_ready_after} !== 2'b01) begin n_fail++; $display("FAIL read_release: got %b expected 01", {obs_br_after, obs_ready_after}); end
    endtask

    task automatic test_split;
        do_transfer(1'b1, 2'd0, 12'h3C5, 8'h81, 8'h00, 1, 5, 0, 0, -1);
        n_checks++; if ({obs_split_rel, obs_regain, obs_resend} !== 3'b110) begin n_fail++; $display("FAIL split_bus: got %b expected 110", {obs_split_rel, obs_regain, obs_resend}); end
        n_checks++; if (obs_wbits !== 8'h81) begin n_fail++; $display("FAIL split_data: got %h expected 81", obs_wbits); end
        n_checks++; if ({obs_done, obs_error} !== 2'b10) begin n_fail++; $display("FAIL split_status: got %b expected 10", {obs_done, obs_error}); end
    endtask

    task automatic test_protocol_error;
        for (int w = 0; w < 2; w++) begin
            do_transfer(1'(w), 2'd3, 12'h456, 8'h99, 8'h5A, 0, 0, 1, 0, -1);
            n_checks++; if ({obs_done, obs_error, obs_br_fin} !== 3'b110) begin n_fail++; $display("FAIL proto_abort_%0d: got %b expected 110", w, {obs_done, obs_error, obs_br_fin}); end
            n_checks++; if (obs_rd !== exp_rd) begin n_fail++; $display("FAIL proto_rd_kept_%0d: got %h expected %h", w, obs_rd, exp_rd); end
            n_checks++; if (obs_ready_after !== 1'b1) begin n_fail++; $display("FAIL proto_idle_%0d: got %b expected 1", w, obs_ready_after); end
        end
    endtask

    task automatic test_timeout;
`ifdef MASTER_TIMEOUT_EN
        int n;
        req_write = 1'b1; req_slave = 2'd3; req_addr = 12'h123; req_wdata = 8'h55; req_valid = 1'b1; response = NAK;
        @(negedge clk);
        req_valid = 1'b0; bus_grant = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(addr === 1'b1 && master_en === 1'b1) && n < 20) begin @(negedge clk); n++; end
        repeat (15) @(negedge clk);
        n = 0;
        do begin @(negedge clk); n++; end while (done !== 1'b1 && n < 100);
        n_checks++; if (n !== 32) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 32", n); end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL timeout_error: got %b expected 1", error); end
        bus_grant = 1'b0;
        @(negedge clk);
        n_checks++; if ({req_ready, bus_request} !== 2'b10) begin n_fail++; $display("FAIL timeout_idle: got %b expected 10", {req_ready, bus_request}); end
`else
        do_transfer(1'b1, 2'd3, 12'h123, 8'h55, 8'h00, 40, 0, 0, 0, -1);
        n_checks++; if (obs_early_done !== 1'b0) begin n_fail++; $display("FAIL nak_wait_early_done: got %b expected 0", obs_early_done); end
        n_checks++; if ({obs_done, obs_error} !== 2'b10) begin n_fail++; $display("FAIL nak_wait_status: got %b expected 10", {obs_done, obs_error}); end
        n_checks++; if (obs_wbits !== 8'h55) begin n_fail++; $display("FAIL nak_wait_data: got %h expected 55", obs_wbits); end
`endif
    endtask

    task automatic test_reset_mid;
        do_transfer(1'b1, 2'd2, 12'h777, 8'hF0, 8'h00, 0, 0, 0, 0, 3);
        @(negedge clk);
        n_checks++; if ({req_ready, bus_request, master_en, addr, w_data, done, error} !== 7'b1000000) begin n_fail++; $display("FAIL midreset_outputs: got %b expected 1000000", {req_ready, bus_request, master_en, addr, w_data, done, error}); end
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL midreset_rd: got %h expected 00", rd_data); end
        reset = 1'b0;
        exp_rd = 8'h00;
        do_transfer(1'b0, 2'd2, 12'h777, 8'h00, 8'hC3, 1, 0, 0, 0, -1);
        exp_rd = 8'hC3;
        n_checks++; if ({obs_hang, obs_done, obs_error} !== 3'b010 || obs_rd !== exp_rd) begin n_fail++; $display("FAIL midreset_recover: got %b/%h expected 010/%h", {obs_hang, obs_done, obs_error}, obs_rd, exp_rd); end
    endtask

    task automatic run_random(input bit hold, input int count);
        logic        wr;
        logic [1:0]  sl;
        logic [11:0] ad;
        logic [7:0]  wd, rd;
        int          busy;
        for (int t = 0; t < count; t++) begin
            wr = 1'($urandom); sl = 2'($urandom); ad = 12'($urandom);
            wd = 8'($urandom); rd = 8'($urandom);
            busy = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
            do_transfer(wr, sl, ad, wd, rd, $urandom_range(0, 4), busy, 0, hold, -1);
            if (!wr) exp_rd = rd;
            n_checks++; if (obs_hdr !== 15'(sl * 8192 + wr * 4096 + ad)) begin n_fail++; $display("FAIL rand_header_%0d_%0d: got %h expected %h", hold, t, obs_hdr, 15'(sl * 8192 + wr * 4096 + ad)); end
            n_checks++; if ({obs_hang, obs_done, obs_error, obs_ready_busy, obs_br_after} !== 5'b01000) begin n_fail++; $display("FAIL rand_status_%0d_%0d: got %b expected 01000", hold, t, {obs_hang, obs_done, obs_error, obs_ready_busy, obs_br_after}); end
            n_checks++; if (obs_rd !== exp_rd) begin n_fail++; $display("FAIL rand_rd_%0d_%0d: got %h expected %h", hold, t, obs_rd, exp_rd); end
            if (wr) begin
                n_checks++; if (obs_wbits !== wd) begin n_fail++; $display("FAIL rand_wdata_%0d_%0d: got %h expected %h", hold, t, obs_wbits, wd); end
            end
            if (busy > 0) begin
                n_checks++; if ({obs_split_rel, obs_regain, obs_resend} !== 3'b110) begin n_fail++; $display("FAIL rand_split_%0d_%0d: got %b expected 110", hold, t, {obs_split_rel, obs_regain, obs_resend}); end
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_random;
        run_random(1'b0, 8);
    endtask

    task automatic test_back_to_back;
        run_random(1'b1, 5);
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_split;
        test_protocol_error;
        test_timeout;
        test_reset_mid;
        test_random;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
